mem_bus_router: RTL and testbench

- Parametrised successor to the 3-port memory bus address decoder. Sits between the core's data/instruction memory port and NUM_PORTS downstream slaves (RAM, ROM, peripherals).
- Decodes the upper address bits and forwards one transaction at a time to the selected slave.
- Takes ready only from the selected slave.
- Completes unmapped-address and timed-out transactions itself with an error response, and records error status.

---
 rtl/mem_bus_router.sv | 172 +++++++++++++++++
 tb/tb_mem_bus_router.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_router.sv
// mem_bus_router
//   Routes one master request at a time to one of NUM_PORTS slaves, chosen by
//   the address field addr[ADDR_WIDTH-1:SEL_LSB]. Unmapped or timed-out
//   requests are completed locally with an error response. The router keeps a
//   saturating error count and the address of the most recent error.
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   s_valid_i          master request valid (held until s_ready_o)
//   s_ready_o          one-cycle completion pulse
//   s_addr_i           request address
//   s_wdata_i          write data
//   s_we_i             byte write enables, all-zero means read
//   s_rdata_o          read data, zero unless s_ready_o is high
//   s_err_o            error completion, qualifies s_ready_o
//   m_valid_o          per-slave valid, at most one bit high
//   m_ready_i          per-slave ready
//   m_addr_o           registered address, replicated on every slave slice
//   m_wdata_o          registered write data, replicated
//   m_we_o             registered byte enables, replicated
//   m_rdata_i          flattened slave read data
//   err_count_o        saturating count of error completions
//   last_err_addr_o    address of the most recent error completion
module mem_bus_router #(
  parameter int NUM_PORTS      = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int SEL_LSB        = 20,
  parameter int TIMEOUT_CYCLES = 255,
  parameter logic [DATA_WIDTH-1:0] ERR_RDATA = 32'hDEADBEEF
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                s_valid_i,
  output logic                                s_ready_o,
  input  logic [ADDR_WIDTH-1:0]               s_addr_i,
  input  logic [DATA_WIDTH-1:0]               s_wdata_i,
  input  logic [DATA_WIDTH/8-1:0]             s_we_i,
  output logic [DATA_WIDTH-1:0]               s_rdata_o,
  output logic                                s_err_o,
  output logic [NUM_PORTS-1:0]                m_valid_o,
  input  logic [NUM_PORTS-1:0]                m_ready_i,
  output logic [NUM_PORTS*ADDR_WIDTH-1:0]     m_addr_o,
  output logic [NUM_PORTS*DATA_WIDTH-1:0]     m_wdata_o,
  output logic [NUM_PORTS*DATA_WIDTH/8-1:0]   m_we_o,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]     m_rdata_i,
  output logic [7:0]                          err_count_o,
  output logic [ADDR_WIDTH-1:0]               last_err_addr_o
);

  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int IDX_W = ADDR_WIDTH - SEL_LSB;
  // Comparison width wide enough to hold NUM_PORTS (up to 16) even when the
  // index field is narrow.
  localparam int CMP_W = (IDX_W > 6) ? IDX_W : 6;
  localparam int SEL_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  // Counter only needs to reach TIMEOUT_CYCLES-1.
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [CMP_W-1:0] NP_CMP   = CMP_W'(NUM_PORTS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ERR  = 2'd2
  } state_t;

  state_t                 state, state_nxt;
  logic [ADDR_WIDTH-1:0]  req_addr;
  logic [DATA_WIDTH-1:0]  req_wdata;
  logic [BE_W-1:0]        req_we;
  logic [SEL_W-1:0]       sel;
  logic [CNT_W-1:0]       cnt;
  logic [7:0]             err_count;
  logic [ADDR_WIDTH-1:0]  last_err_addr;

  logic [IDX_W-1:0]       idx;
  logic                   idx_hit;
  logic                   sel_ready;
  logic                   timeout_hit;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign idx         = s_addr_i[ADDR_WIDTH-1:SEL_LSB];
  assign idx_hit     = CMP_W'(idx) < NP_CMP;
  assign sel_ready   = m_ready_i[sel];
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST);

  // ---- request capture (IDLE accept) ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_addr  <= '0;
      req_wdata <= '0;
      req_we    <= '0;
      sel       <= '0;
    end else if (state == IDLE && s_valid_i) begin
      req_addr  <= s_addr_i;
      req_wdata <= s_wdata_i;
      req_we    <= s_we_i;
      if (idx_hit) begin
        sel <= idx[SEL_W-1:0];
      end
    end
  end

  // ---- control: state, timeout counter, error bookkeeping ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      err_count     <= '0;
      last_err_addr <= '0;
    end else begin
      state <= state_nxt;
      // Counter runs only while the slave is being waited on; any exit from
      // BUSY leaves it cleared for the next transaction.
      if (state == BUSY && !sel_ready && !timeout_hit) begin
        cnt <= cnt + 1'b1;
      end else begin
        cnt <= '0;
      end
      if (state == ERR) begin
        err_count     <= sat_inc8(err_count);
        last_err_addr <= req_addr;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    m_valid_o = '0;
    s_ready_o = 1'b0;
    s_err_o   = 1'b0;
    s_rdata_o = '0;
    case (state)
      IDLE: begin
        if (s_valid_i) begin
          state_nxt = idx_hit ? BUSY : ERR;
        end
      end
      BUSY: begin
        m_valid_o[sel] = 1'b1;
        // Ready in the timeout-boundary cycle takes priority over abort.
        if (sel_ready) begin
          s_ready_o = 1'b1;
          s_rdata_o = m_rdata_i[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
          state_nxt = IDLE;
        end else if (timeout_hit) begin
          state_nxt = ERR;
        end
      end
      ERR: begin
        s_ready_o = 1'b1;
        s_err_o   = 1'b1;
        s_rdata_o = ERR_RDATA;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---- slave-side payload, shared by all slices ----
  assign m_addr_o        = {NUM_PORTS{req_addr}};
  assign m_wdata_o       = {NUM_PORTS{req_wdata}};
  assign m_we_o          = {NUM_PORTS{req_we}};
  assign err_count_o     = err_count;
  assign last_err_addr_o = last_err_addr;

endmodule

// File: tb/tb_mem_bus_router.sv
module tb_mem_bus_router;

  localparam int NP = 4;
  localparam int TO = 6;

  logic          clk;
  logic          rst_n;
  logic          s_valid_i;
  logic          s_ready_o;
  logic [31:0]   s_addr_i;
  logic [31:0]   s_wdata_i;
  logic [3:0]    s_we_i;
  logic [31:0]   s_rdata_o;
  logic          s_err_o;
  logic [NP-1:0] m_valid_o;
  logic [NP-1:0] m_ready_i;
  logic [NP*32-1:0] m_addr_o;
  logic [NP*32-1:0] m_wdata_o;
  logic [NP*4-1:0]  m_we_o;
  logic [NP*32-1:0] m_rdata_i;
  logic [7:0]    err_count_o;
  logic [31:0]   last_err_addr_o;

  int total = 0;
  int bad   = 0;

  // reference bookkeeping
  int          exp_cnt  = 0;
  logic [31:0] exp_last = '0;
  logic [31:0] rd_val [NP];

  mem_bus_router #(
    .NUM_PORTS(NP), .ADDR_WIDTH(32), .DATA_WIDTH(32), .SEL_LSB(20),
    .TIMEOUT_CYCLES(TO), .ERR_RDATA(32'hDEADBEEF)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .s_addr_i(s_addr_i),
    .s_wdata_i(s_wdata_i), .s_we_i(s_we_i), .s_rdata_o(s_rdata_o), .s_err_o(s_err_o),
    .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_addr_o(m_addr_o),
    .m_wdata_o(m_wdata_o), .m_we_o(m_we_o), .m_rdata_i(m_rdata_i),
    .err_count_o(err_count_o), .last_err_addr_o(last_err_addr_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One master transaction. d = BUSY cycle on which the slave raises ready
  // (a value above TO means the slave never answers). Starts at a negedge and
  // returns at the negedge following completion.
  task automatic txn(input logic [31:0] addr, input logic [31:0] wd,
                     input logic [3:0] we, input int d, input logic [31:0] rdv);
    int   idx, lat, vcnt, exp_lat, exp_vcnt;
    bit   mapped, done, other_bad, rd_bad, exp_err, got_err;
    logic [NP-1:0] mask, rdy;
    logic [31:0]   got_rd, exp_rd, cap_addr, cap_wd;
    logic [3:0]    cap_we;

    idx    = int'(addr[31:20]);
    mapped = (idx < NP);
    mask   = mapped ? (NP'(1) << idx) : '0;

    // Behavioural expectation from the routing rules.
    if (!mapped) begin
      exp_err = 1; exp_lat = 2; exp_vcnt = 0;
    end else if (d >= 1 && d <= TO) begin
      exp_err = 0; exp_lat = d + 1; exp_vcnt = d;
    end else begin
      exp_err = 1; exp_lat = TO + 2; exp_vcnt = TO;
    end

    for (int p = 0; p < NP; p++) begin
      rd_val[p] = $urandom;
      if (mapped && p == idx) rd_val[p] = rdv;
      m_rdata_i[p*32 +: 32] = rd_val[p];
    end
    exp_rd = exp_err ? 32'hDEADBEEF : rd_val[mapped ? idx : 0];

    s_addr_i  = addr;
    s_wdata_i = wd;
    s_we_i    = we;
    s_valid_i = 1'b1;

    lat = 0; vcnt = 0; done = 0; other_bad = 0; rd_bad = 0; got_err = 0;
    got_rd = '0; cap_addr = '0; cap_wd = '0; cap_we = '0;
    for (int it = 1; it <= 40 && !done; it++) begin
      @(negedge clk);
      if (mapped && m_valid_o[idx]) begin
        vcnt++;
        if (vcnt == 1) begin
          cap_addr = m_addr_o[idx*32 +: 32];
          cap_wd   = m_wdata_o[idx*32 +: 32];
          cap_we   = m_we_o[idx*4 +: 4];
        end
      end
      if ((m_valid_o & ~mask) != '0) other_bad = 1;
      rdy = NP'($urandom) & ~mask;
      if (mapped && m_valid_o[idx] && vcnt == d) rdy[idx] = 1'b1;
      m_ready_i = rdy;
      #1;
      if (s_ready_o) begin
        done    = 1;
        lat     = it + 1;
        got_rd  = s_rdata_o;
        got_err = s_err_o;
      end else if (s_rdata_o != '0 || s_err_o) begin
        rd_bad = 1;
      end
    end

    chk("complete", 64'(done), 64'd1);
    chk("latency", 64'(lat), 64'(exp_lat));
    chk("s_err", 64'(got_err), 64'(exp_err));
    chk("s_rdata", 64'(got_rd), 64'(exp_rd));
    chk("valid_cycles", 64'(vcnt), 64'(exp_vcnt));
    chk("other_valid", 64'(other_bad), 64'd0);
    chk("idle_rdata", 64'(rd_bad), 64'd0);
    if (mapped) begin
      chk("m_addr", 64'(cap_addr), 64'(addr));
      chk("m_wdata", 64'(cap_wd), 64'(wd));
      chk("m_we", 64'(cap_we), 64'(we));
    end

    @(negedge clk);
    m_ready_i = '0;
    s_valid_i = 1'b0;
    if (exp_err) begin
      if (exp_cnt < 255) exp_cnt++;
      exp_last = addr;
    end
    chk("err_count", 64'(err_count_o), 64'(exp_cnt));
    chk("last_err_addr", 64'(last_err_addr_o), 64'(exp_last));
    chk("valid_after", 64'(m_valid_o), 64'd0);
    chk("ready_after", 64'(s_ready_o), 64'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    s_valid_i = 1'b0;
    s_addr_i  = '0;
    s_wdata_i = '0;
    s_we_i    = '0;
    m_ready_i = '0;
    m_rdata_i = '0;
    #1;
    chk("rst_m_valid", 64'(m_valid_o), 64'd0);
    chk("rst_s_ready", 64'(s_ready_o), 64'd0);
    chk("rst_s_err", 64'(s_err_o), 64'd0);
    chk("rst_s_rdata", 64'(s_rdata_o), 64'd0);
    chk("rst_err_count", 64'(err_count_o), 64'd0);
    chk("rst_last_err", 64'(last_err_addr_o), 64'd0);
    chk("rst_m_addr", 64'(m_addr_o), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // directed: read, slow write, unmapped, timeout and boundary-ready
    txn(32'h0010_0004, 32'h0, 4'b0000, 1, 32'h1234_5678);
    txn(32'h0030_0000, 32'hA5A5_A5A5, 4'b0011, 5, 32'h0);
    txn(32'h0050_0000, 32'h1111_1111, 4'b1111, 1, 32'h0);
    txn(32'h0020_0010, 32'h0, 4'b0000, 99, 32'h0);
    txn(32'h0020_0014, 32'h0, 4'b0000, TO, 32'hCAFE_F00D);
    txn(32'h0000_0000, 32'h0, 4'b0000, TO + 1, 32'h0);

    // randomized mix, with and without idle gaps
    for (int n = 0; n < 150; n++) begin
      logic [31:0] a;
      a = {12'($urandom_range(0, 6)), 20'($urandom)};
      txn(a, $urandom, 4'($urandom), int'($urandom_range(1, TO + 2)), $urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // saturation of the error counter
    for (int n = 0; n < 300; n++) begin
      txn({12'($urandom_range(4, 4095)), 20'($urandom)}, $urandom, 4'($urandom), 1, 32'h0);
    end

    // back-to-back to ports 0/1/0
    txn(32'h0000_0100, 32'h0, 4'b0000, 1, 32'h0101_0101);
    txn(32'h0010_0200, 32'h5, 4'b1000, 2, 32'h0);
    txn(32'h0000_0300, 32'h0, 4'b0000, 1, 32'h0303_0303);

    // asynchronous reset during BUSY
    s_addr_i  = 32'h0020_0000;
    s_wdata_i = '0;
    s_we_i    = '0;
    s_valid_i = 1'b1;
    repeat (2) @(negedge clk);
    chk("pre_rst_valid", 64'(m_valid_o), 64'b0100);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_m_valid", 64'(m_valid_o), 64'd0);
    chk("mid_rst_s_ready", 64'(s_ready_o), 64'd0);
    chk("mid_rst_s_err", 64'(s_err_o), 64'd0);
    chk("mid_rst_err_count", 64'(err_count_o), 64'd0);
    chk("mid_rst_last_err", 64'(last_err_addr_o), 64'd0);
    s_valid_i = 1'b0;
    exp_cnt   = 0;
    exp_last  = '0;
    @(negedge clk);
    rst_n = 1'b1;
    txn(32'h0020_0008, 32'h0, 4'b0000, 2, 32'h7777_8888);
    txn(32'h0070_0000, 32'h0, 4'b0001, 1, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
